// File: rtl/btb_nway_assoc_if.sv
// +----------------------------------------------------------------------+
// | btb_nway_assoc_if : fetch-lookup / branch-update / flush bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface btb_nway_assoc_if #(
    parameter int ADDR_W   = 32,
    parameter int TARGET_W = 32
);
    logic                lookup_valid;
    logic [ADDR_W-1:0]   lookup_pc;
    logic                lookup_hit;
    logic [TARGET_W-1:0] lookup_target;
    logic                update_valid;
    logic [ADDR_W-1:0]   update_pc;
    logic [TARGET_W-1:0] update_target;
    logic                flush;
    logic                busy;

    modport master (
        output lookup_valid, lookup_pc, update_valid, update_pc, update_target, flush,
        input  lookup_hit, lookup_target, busy
    );

    modport slave (
        input  lookup_valid, lookup_pc, update_valid, update_pc, update_target, flush,
        output lookup_hit, lookup_target, busy
    );
endinterface

`default_nettype wire

// File: rtl/btb_nway_assoc.sv
// +----------------------------------------------------------------------+
// | btb_nway_assoc : N-way set-associative BTB, tree PLRU, flush walker  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module btb_nway_assoc #(
    parameter int WAYS     = 4,
    parameter int SETS     = 16,
    parameter int ADDR_W   = 32,
    parameter int TARGET_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    btb_nway_assoc_if.slave   bus
);
    localparam int IW    = $clog2(SETS);
    localparam int LW    = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IW - 2;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_lookup_hit;
    logic [TARGET_W-1:0] r_lookup_target;

    logic [WAYS-1:0]     r_valid  [SETS];
    logic [WAYS-2:0]     r_plru   [SETS];
    logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
    logic [TARGET_W-1:0] r_target [SETS][WAYS];

    // Point every node on the way's root-to-leaf path away from that way.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                   input logic [LW-1:0]   way);
        logic [WAYS-2:0] nxt;
        logic [LW-1:0]   node;
        nxt  = tree;
        node = '0;
        for (int l = LW - 1; l >= 0; l--) begin
            nxt[node] = ~way[l];
            node      = (node << 1) + LW'(1) + LW'(way[l]);
        end
        return nxt;
    endfunction

    function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] tree);
        logic [LW-1:0] vic;
        logic [LW-1:0] node;
        vic  = '0;
        node = '0;
        for (int l = LW - 1; l >= 0; l--) begin
            vic[l] = tree[node];
            node   = (node << 1) + LW'(1) + LW'(tree[node]);
        end
        return vic;
    endfunction

    logic [IW-1:0]    w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IW-1:0]    w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_lk_fire;
    logic             w_up_fire;
    logic             w_lk_hit;
    logic [LW-1:0]    w_lk_way;
    logic             w_up_match;
    logic [LW-1:0]    w_up_match_way;
    logic             w_up_has_inv;
    logic [LW-1:0]    w_up_inv_way;
    logic [LW-1:0]    w_up_way;
    logic             w_unused_pc_lsbs;

    assign w_lk_idx  = bus.lookup_pc[IW+1:2];
    assign w_lk_tag  = bus.lookup_pc[ADDR_W-1:IW+2];
    assign w_up_idx  = bus.update_pc[IW+1:2];
    assign w_up_tag  = bus.update_pc[ADDR_W-1:IW+2];
    assign w_lk_fire = (r_state == S_IDLE) && bus.lookup_valid;
    assign w_up_fire = (r_state == S_IDLE) && bus.update_valid && !bus.flush;
    assign w_unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};

    // Descending scans leave the lowest matching index selected.
    always_comb begin
        w_lk_hit       = 1'b0;
        w_lk_way       = '0;
        w_up_match     = 1'b0;
        w_up_match_way = '0;
        w_up_has_inv   = 1'b0;
        w_up_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_way = LW'(w);
            end
            if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
                w_up_match     = 1'b1;
                w_up_match_way = LW'(w);
            end
            if (!r_valid[w_up_idx][w]) begin
                w_up_has_inv = 1'b1;
                w_up_inv_way = LW'(w);
            end
        end
    end

    assign w_up_way = w_up_match   ? w_up_match_way :
                      w_up_has_inv ? w_up_inv_way   : plru_victim(r_plru[w_up_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_busy          <= 1'b0;
            r_lookup_hit    <= 1'b0;
            r_lookup_target <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_lookup_hit    <= w_lk_fire && w_lk_hit;
            r_lookup_target <= (w_lk_fire && w_lk_hit) ? r_target[w_lk_idx][w_lk_way] : '0;
            case (r_state)
                S_IDLE: begin
                    // An update into the same set overrides the lookup's touch.
                    if (w_lk_fire && w_lk_hit && !(w_up_fire && (w_up_idx == w_lk_idx)))
                        r_plru[w_lk_idx] <= plru_touch(r_plru[w_lk_idx], w_lk_way);
                    if (bus.flush) begin
                        r_state <= S_FLUSH;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (bus.update_valid) begin
                        r_valid[w_up_idx][w_up_way] <= 1'b1;
                        r_plru[w_up_idx]            <= plru_touch(r_plru[w_up_idx], w_up_way);
                    end
                end
                S_FLUSH: begin
                    r_valid[r_cnt] <= '0;
                    r_plru[r_cnt]  <= '0;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == IW'(SETS - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_up_fire) begin
            r_tag[w_up_idx][w_up_way]    <= w_up_tag;
            r_target[w_up_idx][w_up_way] <= bus.update_target;
        end
    end

    assign bus.lookup_hit    = r_lookup_hit;
    assign bus.lookup_target = r_lookup_target;
    assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_btb_nway_assoc.sv
// +----------------------------------------------------------------------+
// | tb_btb_nway_assoc : directed self-checking bench, WAYS=4 SETS=16     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_btb_nway_assoc;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    btb_nway_assoc_if #(.ADDR_W(32), .TARGET_W(32)) bus ();

    btb_nway_assoc #(.WAYS(4), .SETS(16), .ADDR_W(32), .TARGET_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt);
        bus.update_valid  = 1'b1;
        bus.update_pc     = pc;
        bus.update_target = tgt;
        cycle();
        bus.update_valid  = 1'b0;
    endtask

    task automatic lookup_chk(input string tag, input logic [31:0] pc,
                              input logic exp_hit, input logic [31:0] exp_tgt);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc;
        cycle();
        bus.lookup_valid = 1'b0;
        check({tag, ".hit"}, 32'(bus.lookup_hit), 32'(exp_hit));
        check({tag, ".tgt"}, bus.lookup_target, exp_tgt);
    endtask

    initial begin
        int n_busy;
        n_checks          = 0;
        n_errors          = 0;
        rst               = 1'b1;
        bus.lookup_valid  = 1'b0;
        bus.lookup_pc     = '0;
        bus.update_valid  = 1'b0;
        bus.update_pc     = '0;
        bus.update_target = '0;
        bus.flush         = 1'b0;
        cycle();
        check("rst.hit",  32'(bus.lookup_hit), 32'd0);
        check("rst.tgt",  bus.lookup_target,   32'd0);
        check("rst.busy", 32'(bus.busy),       32'd0);
        rst = 1'b0;

        // 1: cold miss, then hit
        lookup_chk("cold", 32'h100, 1'b0, 32'h0);
        do_update(32'h100, 32'h200);
        lookup_chk("basic", 32'h100, 1'b1, 32'h200);
        cycle();
        check("idle.hit", 32'(bus.lookup_hit), 32'd0);

        // 2: fill set 0, touch way 0, victim becomes way 2 (0x080)
        apply_reset();
        do_update(32'h000, 32'h1000);
        do_update(32'h040, 32'h1040);
        do_update(32'h080, 32'h1080);
        do_update(32'h0C0, 32'h10C0);
        lookup_chk("fill0", 32'h000, 1'b1, 32'h1000);
        do_update(32'h100, 32'h1100);
        lookup_chk("evict080", 32'h080, 1'b0, 32'h0);
        lookup_chk("keep000",  32'h000, 1'b1, 32'h1000);
        lookup_chk("keep040",  32'h040, 1'b1, 32'h1040);
        lookup_chk("keep0C0",  32'h0C0, 1'b1, 32'h10C0);
        lookup_chk("new100",   32'h100, 1'b1, 32'h1100);

        // 3: tag-match overwrite without allocation
        do_update(32'h040, 32'h999);
        lookup_chk("ovw040", 32'h040, 1'b1, 32'h999);
        lookup_chk("ovw000", 32'h000, 1'b1, 32'h1000);
        lookup_chk("ovw0C0", 32'h0C0, 1'b1, 32'h10C0);
        lookup_chk("ovw100", 32'h100, 1'b1, 32'h1100);

        // 4: read-before-write
        bus.update_valid  = 1'b1;
        bus.update_pc     = 32'h300;
        bus.update_target = 32'h444;
        lookup_chk("rbw.same", 32'h300, 1'b0, 32'h0);
        bus.update_valid  = 1'b0;
        lookup_chk("rbw.after", 32'h300, 1'b1, 32'h444);

        // 5: flush walk
        do_update(32'h404, 32'hA004);
        do_update(32'h408, 32'hA008);
        do_update(32'h40C, 32'hA00C);
        do_update(32'h410, 32'hA010);
        lookup_chk("pre404", 32'h404, 1'b1, 32'hA004);
        lookup_chk("pre410", 32'h410, 1'b1, 32'hA010);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        n_busy = 0;
        while (bus.busy && n_busy < 40) begin
            bus.lookup_valid  = 1'b1;
            bus.lookup_pc     = 32'h404;
            bus.update_valid  = 1'b1;
            bus.update_pc     = 32'h514;
            bus.update_target = 32'h777;
            bus.flush         = (n_busy == 3);
            cycle();
            check("busy.hit", 32'(bus.lookup_hit), 32'd0);
            n_busy++;
        end
        bus.lookup_valid = 1'b0;
        bus.update_valid = 1'b0;
        bus.flush        = 1'b0;
        check("busy.len", 32'(n_busy), 32'd16);
        check("busy.end", 32'(bus.busy), 32'd0);
        lookup_chk("fl404", 32'h404, 1'b0, 32'h0);
        lookup_chk("fl408", 32'h408, 1'b0, 32'h0);
        lookup_chk("fl40C", 32'h40C, 1'b0, 32'h0);
        lookup_chk("fl410", 32'h410, 1'b0, 32'h0);
        lookup_chk("fl300", 32'h300, 1'b0, 32'h0);
        lookup_chk("fl000", 32'h000, 1'b0, 32'h0);
        lookup_chk("fl514", 32'h514, 1'b0, 32'h0);

        // 6: async reset drops registered hit without a clock edge
        do_update(32'h420, 32'h420A);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h420;
        cycle();
        bus.lookup_valid = 1'b0;
        check("arst.prehit", 32'(bus.lookup_hit), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst.hit", 32'(bus.lookup_hit), 32'd0);
        check("arst.tgt", bus.lookup_target,   32'd0);
        #1 rst = 1'b0;

        // async reset in the middle of a flush walk
        do_update(32'h420, 32'h420A);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        repeat (4) cycle();
        check("mid.prebusy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid.busy", 32'(bus.busy),       32'd0);
        check("mid.hit",  32'(bus.lookup_hit), 32'd0);
        #1 rst = 1'b0;
        lookup_chk("post420", 32'h420, 1'b0, 32'h0);
        lookup_chk("post404", 32'h404, 1'b0, 32'h0);
        do_update(32'h428, 32'hABC);
        lookup_chk("post428", 32'h428, 1'b1, 32'hABC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/btb_nway_assoc.md
Name: btb_nway_assoc

Overview:
- Parametrised N-way set-associative branch target buffer with integrated storage, tree pseudo-LRU replacement, a write/allocate update port and a multi-cycle flush sequencer.
- Sits beside the fetch stage: fetch presents a PC for lookup, and the branch-resolution stage writes taken-branch targets back.
- Generalises the existing 2-way BTB control to WAYS ways and SETS sets, with tag-match overwrite and a flush walk.

Parameters:
- WAYS, 4, associativity; power of 2, at least 2.
- SETS, 16, number of sets; power of 2, at least 2.
- ADDR_W, 32, PC width.
- TARGET_W, 32, stored target width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lookup_valid  in  1  lookup request this cycle
- lookup_pc  in  ADDR_W  fetch PC
- lookup_hit  out  1  registered; lookup issued last cycle hit
- lookup_target  out  TARGET_W  registered target for that hit; 0 on miss
- update_valid  in  1  write request this cycle
- update_pc  in  ADDR_W  branch PC
- update_target  in  TARGET_W  resolved target
- flush  in  1  one-cycle pulse; invalidate whole BTB
- busy  out  1  high while flush walk is in progress

Behaviour:
- Address split, with IW = log2(SETS):
  - index = PC[IW+1:2]
  - tag = PC[ADDR_W-1:IW+2]
  - PC[1:0] is ignored.
- Per set: WAYS valid bits, WAYS tags, WAYS targets, and WAYS-1 PLRU tree bits.
- Async rst:
  - All valid and PLRU bits clear immediately.
  - FSM goes to IDLE.
  - lookup_hit, lookup_target and busy all go to 0.
  - The tag and target arrays need no reset.
- Lookup:
  - Latency is exactly 1 cycle.
  - A lookup_valid at edge N produces lookup_hit/lookup_target after edge N.
  - With no lookup_valid, lookup_hit=0 the next cycle.
  - A hit touches the PLRU for the hitting way at the same edge.
- Update:
  - Takes effect at the edge where update_valid=1.
  - Tag match in the set (valid): overwrite that way's target, touch its PLRU, no allocation.
  - Else, an invalid way exists: allocate the lowest-index invalid way.
  - Else: allocate the PLRU victim.
  - On allocate: write the tag and target, set valid, and touch that way.
- PLRU tree:
  - Node 0 is the root; the children of node k are 2k+1 and 2k+2.
  - Leaves map to ways left to right.
  - Bit=1 means the victim lies in the upper (right) subtree.
  - Touch way w: every node on w's path is set to point away from w.
  - Victim: follow the bits from the root.
- Simultaneous lookup and update in the same cycle:
  - Lookup sees pre-edge contents (read-before-write); a lookup of the same PC misses or returns the old target.
  - Same set with both touching the PLRU: the update's touch wins.
- FSM states:
  - IDLE: flush=1 -> FLUSH, with the set counter loaded to 0.
  - FLUSH: each cycle clear the valid and PLRU bits of set[counter], then increment.
  - FLUSH: counter==SETS-1 -> IDLE. The counter wraps to 0; it never indexes out of range.
- busy=1 in FLUSH for exactly SETS cycles.
- While busy:
  - Lookups return hit=0.
  - Updates are dropped.
  - flush pulses are ignored; there is no restart.
- flush and update in the same IDLE cycle: flush wins and the update is dropped.
- rst during FLUSH: immediate return to IDLE with the BTB fully invalid.

Test Plan:
Configuration for all scenarios: WAYS=4, SETS=16, so index = PC[5:2].
1. Cold miss and basic hit:
   - Release rst, then lookup 0x100 -> next cycle lookup_hit=0, lookup_target=0.
   - Update 0x100 with target 0x200, then lookup 0x100 -> hit=1, target=0x200.
2. PLRU eviction:
   - Update 0x000, 0x040, 0x080, 0x0C0 (set 0; ways 0-3 allocated in order), then lookup 0x000 (hit).
   - Update 0x100 -> way 2 is evicted.
   - Lookup 0x080 -> miss.
   - Lookups 0x000, 0x040, 0x0C0 and 0x100 -> all hit.
3. Tag-match overwrite:
   - With set 0 full, update 0x040 with target 0x999.
   - Lookup 0x040 -> 0x999; the other three entries are still resident.
4. Read-before-write:
   - Same cycle: lookup and update of 0x300 with target 0x444 -> next cycle hit=0.
   - Repeat the lookup -> hit=1, target 0x444.
5. Flush walk:
   - Populate 4 sets, then pulse flush -> busy=1 for exactly 16 cycles.
   - Lookups and updates issued during busy -> miss and no effect.
   - After busy drops, every earlier PC misses.
6. Async reset mid-flush:
   - Assert rst at flush cycle 5 -> busy=0 and lookup_hit=0 immediately, without waiting for a clock.
   - After release, all lookups miss and a new update/lookup pair works normally.
